key_duty_ctrl: RTL and testbench

Upstream control stage for the LED PWM generator. It synchronises and debounces the two board push-buttons and turns them into a duty word on `o_duty`, which feeds the PWM generator's duty input directly. Each press or auto-repeat steps the duty up or down with saturation. Pressing both keys together toggles an autonomous triangle-wave "breathing" mode.

---
 rtl/key_duty_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_key_duty_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_duty_ctrl.sv
// Push-button front end for the LED PWM: synchronise, debounce, step/auto-repeat the duty word.
// Optional triangle "breathing" mode is compiled in when KEY_DUTY_BREATHE_EN is defined.
module key_duty_ctrl #(
    parameter int RESOLUTION      = 8,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int TICK_CYCLES     = 135000,
    parameter int STEP            = 16,
    parameter int REPEAT_DELAY    = 100,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_key_up,
    input  logic                  i_key_down,
    output logic [RESOLUTION-1:0] o_duty,
    output logic                  o_breathe
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int REP_W  = $clog2(REPEAT_PERIOD + 1);
    localparam int W1     = RESOLUTION + 1;
    localparam logic [RESOLUTION:0] STEP_X = W1'(STEP);

    // Bit 0 is the up key, bit 1 the down key throughout.
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      db_q, db_d, db_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      pressed;

    logic [TICK_W-1:0] pre_q, pre_d;
    logic              tick;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              rep_step;

    logic [1:0] rise;
    logic       chord, press_up, press_dn, one_held, in_manual;

    logic [RESOLUTION-1:0] duty_q, duty_d;
    logic [RESOLUTION:0]   sum_up, diff_dn;
    logic [RESOLUTION-1:0] up_sat, dn_sat;

    assign pressed = ~sync_q;

    always_comb begin
        db_d = db_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            if (pressed[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[k] = pressed[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign tick  = (pre_q == TICK_W'(TICK_CYCLES - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    assign rise     = db_q & ~db_prev_q;
    assign chord    = (&db_q) & ~(&db_prev_q);
    assign press_up = rise[0] & ~db_q[1];
    assign press_dn = rise[1] & ~db_q[0];
    assign one_held = ^db_q;

    // hold_q saturates at REPEAT_DELAY; rep_q then paces the repeat period.
    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rep_step = 1'b0;
        if (!one_held || press_up || press_dn || chord || !in_manual) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (tick) begin
            if (hold_q != HOLD_W'(REPEAT_DELAY)) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(REPEAT_DELAY - 1)) begin
                    rep_step = 1'b1;
                end
            end else if (rep_q == REP_W'(REPEAT_PERIOD - 1)) begin
                rep_d    = '0;
                rep_step = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    // One guard bit catches overflow and borrow for saturation.
    assign sum_up  = {1'b0, duty_q} + STEP_X;
    assign diff_dn = {1'b0, duty_q} - STEP_X;
    assign up_sat  = sum_up[RESOLUTION]  ? '1 : sum_up[RESOLUTION-1:0];
    assign dn_sat  = diff_dn[RESOLUTION] ? '0 : diff_dn[RESOLUTION-1:0];

`ifdef KEY_DUTY_BREATHE_EN
    localparam logic [RESOLUTION-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_BR_UP   = 2'd1,
        ST_BR_DOWN = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   breathe_q;

    assign in_manual = (state_q == ST_MANUAL);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_MANUAL: begin
                if (chord) begin
                    state_d = ST_BR_UP;
                end else if (press_up || (rep_step && db_q[0])) begin
                    duty_d = up_sat;
                end else if (press_dn || (rep_step && db_q[1])) begin
                    duty_d = dn_sat;
                end
            end
            ST_BR_UP: begin
                if (chord) begin
                    state_d = ST_MANUAL;
                end else if (tick) begin
                    if (duty_q == DUTY_MAX) begin
                        duty_d  = duty_q - 1'b1;
                        state_d = ST_BR_DOWN;
                    end else begin
                        duty_d = duty_q + 1'b1;
                    end
                end
            end
            ST_BR_DOWN: begin
                if (chord) begin
                    state_d = ST_MANUAL;
                end else if (tick) begin
                    if (duty_q == '0) begin
                        duty_d  = duty_q + 1'b1;
                        state_d = ST_BR_UP;
                    end else begin
                        duty_d = duty_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_MANUAL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_MANUAL;
            breathe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            breathe_q <= (state_d != ST_MANUAL);
        end
    end

    assign o_breathe = breathe_q;
`else
    assign in_manual = 1'b1;

    // Without breathing, a chord is a quick way back to zero.
    always_comb begin
        duty_d = duty_q;
        if (chord) begin
            duty_d = '0;
        end else if (press_up || (rep_step && db_q[0])) begin
            duty_d = up_sat;
        end else if (press_dn || (rep_step && db_q[1])) begin
            duty_d = dn_sat;
        end
    end

    assign o_breathe = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q    <= 2'b11;
            sync_q    <= 2'b11;
            db_q      <= 2'b00;
            db_prev_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
            pre_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            duty_q    <= '0;
        end else begin
            meta_q    <= {i_key_down, i_key_up};
            sync_q    <= meta_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            duty_q    <= duty_d;
        end
    end

    assign o_duty = duty_q;

endmodule

// File: tb/tb_key_duty_ctrl.sv
// Bench for key_duty_ctrl: vector table, hand sequences and random keys checked against a cycle model.
module tb_key_duty_ctrl;

    localparam int RES_C  = 8;
    localparam int DB_C   = 4;
    localparam int TK_C   = 2;
    localparam int STEP_C = 16;
    localparam int RD_C   = 3;
    localparam int RP_C   = 2;
    localparam int MAX_C  = (1 << RES_C) - 1;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             key_up = 1'b1;
    logic             key_dn = 1'b1;
    logic [RES_C-1:0] duty;
    logic             breathe;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    key_duty_ctrl #(
        .RESOLUTION     (RES_C),
        .DEBOUNCE_CYCLES(DB_C),
        .TICK_CYCLES    (TK_C),
        .STEP           (STEP_C),
        .REPEAT_DELAY   (RD_C),
        .REPEAT_PERIOD  (RP_C)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_up  (key_up),
        .i_key_down(key_dn),
        .o_duty    (duty),
        .o_breathe (breathe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, one call per clock edge. Debounce is a window test over the
    // last DB_C pressed samples; repeat timing is modular arithmetic on held ticks.
    int m_duty, m_br, m_pre, m_hold;
    bit m_db [2];
    bit m_dbp[2];
    bit m_r1 [2];
    bit m_ph [2][DB_C];

    task automatic model_reset();
        m_duty = 0; m_br = 0; m_pre = 0; m_hold = 0;
        for (int k = 0; k < 2; k++) begin
            m_db[k] = 0; m_dbp[k] = 0; m_r1[k] = 1;
            for (int j = 0; j < DB_C; j++) m_ph[k][j] = 0;
        end
    endtask

    task automatic model_step();
        bit raw[2];
        bit tick, chord, pu, pd, rep, flip;
        raw[0] = key_up;
        raw[1] = key_dn;
        tick  = (m_pre == TK_C - 1);
        pu    = m_db[0] && !m_dbp[0] && !m_db[1];
        pd    = m_db[1] && !m_dbp[1] && !m_db[0];
        chord = m_db[0] && m_db[1] && !(m_dbp[0] && m_dbp[1]);
        rep   = 0;
        if ((m_db[0] == m_db[1]) || pu || pd || chord || m_br != 0) begin
            m_hold = 0;
        end else if (tick) begin
            m_hold = m_hold + 1;
            rep = (m_hold == RD_C) || (m_hold > RD_C && ((m_hold - RD_C) % RP_C) == 0);
        end
        if (m_br == 0) begin
            if (chord) begin
`ifdef KEY_DUTY_BREATHE_EN
                m_br = 1;
`else
                m_duty = 0;
`endif
            end else if (pu || (rep && m_db[0])) begin
                m_duty = (m_duty + STEP_C > MAX_C) ? MAX_C : m_duty + STEP_C;
            end else if (pd || (rep && m_db[1])) begin
                m_duty = (m_duty < STEP_C) ? 0 : m_duty - STEP_C;
            end
        end else if (chord) begin
            m_br = 0;
        end else if (tick) begin
            if (m_br == 1) begin
                if (m_duty == MAX_C) begin m_duty = m_duty - 1; m_br = 2; end
                else m_duty = m_duty + 1;
            end else begin
                if (m_duty == 0) begin m_duty = 1; m_br = 1; end
                else m_duty = m_duty - 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            flip = 1;
            for (int j = 0; j < DB_C; j++) if (m_ph[k][j] == m_db[k]) flip = 0;
            m_dbp[k] = m_db[k];
            if (flip) m_db[k] = !m_db[k];
            for (int j = DB_C - 1; j > 0; j--) m_ph[k][j] = m_ph[k][j-1];
            m_ph[k][0] = !m_r1[k];
            m_r1[k] = raw[k];
        end
        m_pre = (m_pre + 1) % TK_C;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_duty", int'(duty), m_duty);
            chk("model_breathe", int'(breathe), (m_br != 0) ? 1 : 0);
        end
    end

    // Drivers: inputs change just after the falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; key_up = 1'b0; key_dn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_duty", int'(duty), 0);
        chk("reset_breathe", int'(breathe), 0);
        key_up = 1'b1; key_dn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit up_n, input bit dn_n, input int hold, input int rel);
        @(negedge clk);
        key_up = up_n; key_dn = dn_n;
        repeat (hold) @(negedge clk);
        key_up = 1'b1; key_dn = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    task automatic wait_duty(input string name, input int val, input int max_cyc);
        int n = 0;
        while (int'(duty) != val && n < max_cyc) begin @(negedge clk); n++; end
        chk(name, int'(duty), val);
    endtask

    task automatic wait_br(input string name, input int val, input int max_cyc);
        int n = 0;
        while (int'(breathe) != val && n < max_cyc) begin @(negedge clk); n++; end
        chk(name, int'(breathe), val);
    endtask

    task automatic wait_change(input string name, input int exp, input int max_cyc);
        int n = 0;
        logic [RES_C-1:0] prev;
        prev = duty;
        while (duty == prev && n < max_cyc) begin @(negedge clk); n++; end
        chk(name, int'(duty), exp);
    endtask

    typedef struct {
        bit up_n;
        bit dn_n;
        int hold;
        int rel;
        int exp_duty;
        int exp_br;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[$];
        int times[$];
        int cyc, nchg, cu, cd;
        logic [RES_C-1:0] last;

        // Table: a short glitch, 17 up presses into saturation, one down press.
        vecs.push_back('{1'b0, 1'b1, 3, 8, 0, 0});
        for (int i = 1; i <= 17; i++)
            vecs.push_back('{1'b0, 1'b1, 5, 8, (16 * i > MAX_C) ? MAX_C : 16 * i, 0});
        vecs.push_back('{1'b1, 1'b0, 5, 8, 239, 0});

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        apply_reset();
        foreach (vecs[i]) begin
            press(vecs[i].up_n, vecs[i].dn_n, vecs[i].hold, vecs[i].rel);
            chk($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty);
            chk($sformatf("vec%0d_breathe", i), int'(breathe), vecs[i].exp_br);
        end

        // Auto-repeat down from 64.
        apply_reset();
        repeat (4) press(1'b0, 1'b1, 5, 8);
        chk("rep_start", int'(duty), 64);
        @(negedge clk);
        key_dn = 1'b0;
        last = duty;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (duty != last) begin vals.push_back(int'(duty)); times.push_back(cyc); end
            last = duty;
        end
        key_dn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rep_nsteps", vals.size(), 4);
        if (vals.size() == 4) begin
            chk("rep_v0", vals[0], 48);
            chk("rep_v1", vals[1], 32);
            chk("rep_v2", vals[2], 16);
            chk("rep_v3", vals[3], 0);
            chk("rep_first_gap", ((times[1] - times[0]) == 5 || (times[1] - times[0]) == 6) ? 1 : 0, 1);
            chk("rep_gap2", times[2] - times[1], 4);
            chk("rep_gap3", times[3] - times[2], 4);
        end
        chk("rep_floor", int'(duty), 0);

`ifdef KEY_DUTY_BREATHE_EN
        apply_reset();
        repeat (15) press(1'b0, 1'b1, 5, 8);
        chk("br_start", int'(duty), 240);
        @(negedge clk);
        key_up = 1'b0; key_dn = 1'b0;
        wait_br("br_on", 1, 20);
        chk("br_hold_duty", int'(duty), 240);
        wait_duty("br_top", MAX_C, 100);
        wait_change("br_turn_down", MAX_C - 1, 10);
        wait_duty("br_bottom", 0, 1200);
        wait_change("br_turn_up", 1, 10);
        key_up = 1'b1; key_dn = 1'b1;
        repeat (10) @(negedge clk);
        key_up = 1'b0; key_dn = 1'b0;
        wait_br("br_exit", 0, 20);
        last = duty;
        nchg = 0;
        repeat (20) begin
            @(negedge clk);
            if (duty != last) nchg++;
            last = duty;
        end
        chk("br_frozen_changes", nchg, 0);
        chk("br_frozen_model", int'(duty), m_duty);
        key_up = 1'b1; key_dn = 1'b1;
        repeat (10) @(negedge clk);
        key_up = 1'b0; key_dn = 1'b0;
        wait_br("br_reenter", 1, 20);
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("br_async_duty", int'(duty), 0);
        chk("br_async_breathe", int'(breathe), 0);
        key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`else
        apply_reset();
        repeat (8) press(1'b0, 1'b1, 5, 8);
        chk("chord_start", int'(duty), 128);
        press(1'b0, 1'b0, 10, 10);
        chk("chord_clear_duty", int'(duty), 0);
        chk("chord_clear_breathe", int'(breathe), 0);
`endif

        // Random key activity, including glitches and chords.
        apply_reset();
        cu = 1; cd = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cu = cu - 1;
            cd = cd - 1;
            if (cu == 0) begin key_up = ~key_up; cu = $urandom_range(1, 20); end
            if (cd == 0) begin key_dn = ~key_dn; cd = $urandom_range(1, 20); end
        end
        key_up = 1'b1; key_dn = 1'b1;
        repeat (10) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
